pipeline_skid_stage: RTL and testbench
======================================

Name: pipeline_skid_stage

Overview:
- Parametrised, generic inter-stage pipeline register for the RV32I pipelined core. It replaces the fixed per-stage register banks (ID/EX, EX/MEM, MEM/WB) with one block.
- Adds a valid/ready handshake, synchronous flush and an optional two-entry skid buffer, so back-pressure from a slow memory stage does not create a combinational ready path through the pipeline.
- Control fields are forced to zero on bubbles, so register and memory write enables never fire for invalid slots.
- Also provides a saturating stall-cycle performance counter.

Parameters:
- CTRL_W, 9, width of the packed control bundle (reg_wr_en, result_src, mux_sel, mem_wr_en, mem_byte_sel).
- DATA_W, 165, width of the packed datapath bundle (alu_result, writedata, rd_addr, ExtImm, PCPlus4, PCTarget).
- SKID, 1, 1 = two-entry skid buffer with registered o_ready; 0 = single register with combinational o_ready.
- CLR_CTRL, 1, 1 = o_ctrl reads zero whenever o_valid=0.
- CNT_W, 16, width of the stall counter.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rstn  in  1  asynchronous active-low reset.
- i_flush  in  1  synchronous flush: kill all held entries.
- i_valid  in  1  upstream entry valid.
- o_ready  out  1  stage can accept an entry this cycle.
- i_ctrl  in  CTRL_W  upstream control bundle.
- i_data  in  DATA_W  upstream datapath bundle.
- o_valid  out  1  downstream entry valid.
- i_ready  in  1  downstream accepts this cycle.
- o_ctrl  out  CTRL_W  registered control bundle.
- o_data  out  DATA_W  registered datapath bundle.
- i_cnt_clr  in  1  synchronous clear of the stall counter.
- o_stall_cnt  out  CNT_W  cycles with o_valid=1 and i_ready=0.

Behaviour:
- Reset (async, i_rstn=0): main_valid=0, skid_valid=0, o_valid=0, o_ctrl=0, o_data=0, o_stall_cnt=0, o_ready=1. The reset takes effect immediately mid-transfer, and any held entries are lost.
- Transfers: an input transfer occurs when i_valid & o_ready; an output transfer occurs when o_valid & i_ready. Latency is 1 cycle from input transfer to o_valid when the stage is empty.
- SKID=0:
  - o_ready = i_ready | ~main_valid (combinational).
  - On an input transfer, main <= input and main_valid <= 1.
  - Otherwise, on an output transfer, main_valid <= 0.
- SKID=1 state machine, with states EMPTY, ONE and FULL encoded by {skid_valid, main_valid}:
  - o_ready = ~skid_valid (registered, no path from i_ready).
  - EMPTY, input transfer: main <= input, go to ONE.
  - ONE, input transfer and i_ready: main <= input, stay in ONE.
  - ONE, input transfer and ~i_ready: skid <= input, go to FULL. main holds.
  - ONE, no input transfer and i_ready: go to EMPTY.
  - FULL and i_ready: main <= skid, go to ONE. No input is accepted, because o_ready=0 in FULL.
  - FULL and ~i_ready: hold.
  - Ordering is strictly FIFO: main is always the older entry.
- Flush:
  - i_flush=1 forces the next state to EMPTY. It overrides a simultaneous input transfer, so that entry is dropped.
  - Data registers are not cleared.
  - Flush and stall in the same cycle: flush wins.
- Output mapping: o_valid = main_valid. o_data = main data, which holds its last value while invalid. o_ctrl = main ctrl & {CTRL_W{main_valid | ~CLR_CTRL}}.
- Stall counter:
  - Increments when o_valid & ~i_ready.
  - Saturates at 2^CNT_W-1 and does not wrap.
  - i_cnt_clr has priority over increment: the clear sets the counter to 0 and no increment occurs that cycle.
  - i_flush does not affect the counter.
- Width rules: no arithmetic on the bundles, which pass through bit-exact. The counter is unsigned.

Decomposition:
- Shared package (common riscv_configs): state localparams ST_EMPTY=2'b00, ST_ONE=2'b01 and ST_FULL=2'b11, plus the control-bundle field offsets used to pack and unpack CTRL_W.
- One sub-module: pipeline_sat_counter (params CNT_W; ports i_clk, i_rstn, i_inc, i_clr, o_cnt), instantiated for the stall counter.

Test Plan:
- Reset mid-stream: hold FULL with o_data=0xAA…, assert i_rstn=0 -> immediately o_valid=0, o_ctrl=0, o_data=0, o_stall_cnt=0, and o_ready=1 after release.
- Streaming with SKID=1 and i_ready=1: send 8 entries with data=1..8, back-to-back -> outputs 1..8 in consecutive cycles starting 1 cycle after the first input, o_ready held at 1.
- Back-pressure with SKID=1: send A=0x11 and B=0x22, drop i_ready for 3 cycles -> state FULL, o_ready=0, o_data=0x11, o_stall_cnt=3. Raise i_ready -> 0x11 then 0x22 out with no loss or duplication.
- Flush with simultaneous input: in FULL, assert i_flush with i_valid=1 and data=0x33 -> next cycle o_valid=0, o_ctrl=0, o_ready=1, and 0x33 never appears at the output.
- Bubble control clear: CLR_CTRL=1 and i_ctrl=9'h1FF with i_valid=0 -> o_ctrl=0. With CLR_CTRL=0, the previously held ctrl stays visible.
- Counter saturation and clear: CNT_W=4, stall 20 cycles -> o_stall_cnt=15. Assert i_cnt_clr while still stalling -> 0 in the next cycle, then counts 1, 2, ….

Source files
------------

// File: rtl/pipeline_skid_stage_pkg.sv
// Shared definitions for the generic inter-stage pipeline register:
// skid FSM state encoding and the packed control-bundle layout.
package pipeline_skid_stage_pkg;

    // The encoding equals {skid_valid, main_valid}, so the state is the valid bits themselves.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b11
    } skid_state_e;

    localparam int CTRL_REG_WR_EN_OFF    = 0;
    localparam int CTRL_RESULT_SRC_OFF   = 1;
    localparam int CTRL_MUX_SEL_OFF      = 3;
    localparam int CTRL_MEM_WR_EN_OFF    = 5;
    localparam int CTRL_MEM_BYTE_SEL_OFF = 6;
    localparam int CTRL_BUNDLE_W         = 9;
    localparam int DATA_BUNDLE_W         = 165;

    function automatic logic [CTRL_BUNDLE_W-1:0] pack_ctrl(
        input logic       reg_wr_en,
        input logic [1:0] result_src,
        input logic [1:0] mux_sel,
        input logic       mem_wr_en,
        input logic [2:0] mem_byte_sel
    );
        logic [CTRL_BUNDLE_W-1:0] c;
        c = '0;
        c[CTRL_REG_WR_EN_OFF]                               = reg_wr_en;
        c[CTRL_RESULT_SRC_OFF +: 2]                         = result_src;
        c[CTRL_MUX_SEL_OFF +: 2]                            = mux_sel;
        c[CTRL_MEM_WR_EN_OFF]                               = mem_wr_en;
        c[CTRL_MEM_BYTE_SEL_OFF +: 3]                       = mem_byte_sel;
        return c;
    endfunction

endpackage

// File: rtl/pipeline_sat_counter.sv
// Saturating up-counter with a synchronous clear that takes priority over increment.
module pipeline_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_cnt = cnt_q;

endmodule

// File: rtl/pipeline_skid_stage.sv
// Generic valid/ready pipeline register with optional two-entry skid buffer,
// synchronous flush, bubble control clearing and a saturating stall counter.
module pipeline_skid_stage
    import pipeline_skid_stage_pkg::*;
#(
    parameter int CTRL_W   = CTRL_BUNDLE_W,
    parameter int DATA_W   = DATA_BUNDLE_W,
    parameter int SKID     = 1,
    parameter int CLR_CTRL = 1,
    parameter int CNT_W    = 16
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_flush,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [DATA_W-1:0] o_data,
    input  logic              i_cnt_clr,
    output logic [CNT_W-1:0]  o_stall_cnt,
    output logic [1:0]        o_dbg_state
);

    localparam logic SKID_EN = (SKID != 0);
    localparam logic CLR_EN  = (CLR_CTRL != 0);

    // Handshake: a transfer happens on any edge where valid & ready are both high.
    logic              main_valid_q;
    logic              skid_valid_q;
    logic [CTRL_W-1:0] main_ctrl_q;
    logic [DATA_W-1:0] main_data_q;
    logic [CTRL_W-1:0] skid_ctrl_q;
    logic [DATA_W-1:0] skid_data_q;
    logic              in_xfer;
    skid_state_e       state;

    assign state   = skid_state_e'({skid_valid_q, main_valid_q});
    assign o_ready = SKID_EN ? ~skid_valid_q : (i_ready | ~main_valid_q);
    assign in_xfer = i_valid & o_ready;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_ctrl_q  <= '0;
            main_data_q  <= '0;
            skid_ctrl_q  <= '0;
            skid_data_q  <= '0;
        end else if (i_flush) begin
            // Only the valid bits are killed; data registers keep their contents.
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (!SKID_EN) begin
            if (in_xfer) begin
                main_ctrl_q  <= i_ctrl;
                main_data_q  <= i_data;
                main_valid_q <= 1'b1;
            end else if (main_valid_q && i_ready) begin
                main_valid_q <= 1'b0;
            end
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        main_ctrl_q  <= i_ctrl;
                        main_data_q  <= i_data;
                        main_valid_q <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (in_xfer && i_ready) begin
                        main_ctrl_q <= i_ctrl;
                        main_data_q <= i_data;
                    end else if (in_xfer) begin
                        skid_ctrl_q  <= i_ctrl;
                        skid_data_q  <= i_data;
                        skid_valid_q <= 1'b1;
                    end else if (i_ready) begin
                        main_valid_q <= 1'b0;
                    end
                end
                ST_FULL: begin
                    // The skid entry is younger, so it moves into main once main drains.
                    if (i_ready) begin
                        main_ctrl_q  <= skid_ctrl_q;
                        main_data_q  <= skid_data_q;
                        skid_valid_q <= 1'b0;
                    end
                end
                default: begin
                    main_valid_q <= 1'b0;
                    skid_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_valid     = main_valid_q;
    assign o_data      = main_data_q;
    assign o_ctrl      = main_ctrl_q & {CTRL_W{main_valid_q | ~CLR_EN}};
    assign o_dbg_state = state;

    pipeline_sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .i_inc  (main_valid_q & ~i_ready),
        .i_clr  (i_cnt_clr),
        .o_cnt  (o_stall_cnt)
    );

endmodule

// File: tb/tb_pipeline_skid_stage.sv
// Directed bench: instance A uses the defaults (skid buffer, bubble clear),
// instance B is a single register without bubble clear and a 4-bit counter.
module tb_pipeline_skid_stage;
    import pipeline_skid_stage_pkg::*;

    localparam int AD_W = 165;
    localparam int BD_W = 8;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic            a_flush, a_valid, a_ready_i, a_clr;
    logic [8:0]      a_ctrl;
    logic [AD_W-1:0] a_data;
    logic            a_ready_o, a_valid_o;
    logic [8:0]      a_ctrl_o;
    logic [AD_W-1:0] a_data_o;
    logic [15:0]     a_cnt;
    logic [1:0]      a_state;

    logic            b_flush, b_valid, b_ready_i, b_clr;
    logic [8:0]      b_ctrl;
    logic [BD_W-1:0] b_data;
    logic            b_ready_o, b_valid_o;
    logic [8:0]      b_ctrl_o;
    logic [BD_W-1:0] b_data_o;
    logic [3:0]      b_cnt;
    logic [1:0]      b_state;

    int n_cmp = 0;
    int n_err = 0;
    logic [AD_W-1:0] exp_q[$];
    logic [AD_W-1:0] exp_v;

    pipeline_skid_stage dut_a (
        .i_clk(clk), .i_rstn(rstn), .i_flush(a_flush), .i_valid(a_valid),
        .o_ready(a_ready_o), .i_ctrl(a_ctrl), .i_data(a_data), .o_valid(a_valid_o),
        .i_ready(a_ready_i), .o_ctrl(a_ctrl_o), .o_data(a_data_o), .i_cnt_clr(a_clr),
        .o_stall_cnt(a_cnt), .o_dbg_state(a_state)
    );

    pipeline_skid_stage #(
        .CTRL_W(9), .DATA_W(BD_W), .SKID(0), .CLR_CTRL(0), .CNT_W(4)
    ) dut_b (
        .i_clk(clk), .i_rstn(rstn), .i_flush(b_flush), .i_valid(b_valid),
        .o_ready(b_ready_o), .i_ctrl(b_ctrl), .i_data(b_data), .o_valid(b_valid_o),
        .i_ready(b_ready_i), .o_ctrl(b_ctrl_o), .o_data(b_data_o), .i_cnt_clr(b_clr),
        .o_stall_cnt(b_cnt), .o_dbg_state(b_state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        a_flush = 0; a_valid = 0; a_ready_i = 1; a_clr = 0; a_ctrl = '0; a_data = '0;
        b_flush = 0; b_valid = 0; b_ready_i = 1; b_clr = 0; b_ctrl = '0; b_data = '0;
        #2;
        n_cmp++; if (a_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", a_valid_o); end
        n_cmp++; if (a_ctrl_o !== 9'h0) begin n_err++; $display("FAIL reset_ctrl got %h want 0", a_ctrl_o); end
        n_cmp++; if (a_data_o !== '0) begin n_err++; $display("FAIL reset_data got %h want 0", a_data_o); end
        n_cmp++; if (a_cnt !== 16'd0) begin n_err++; $display("FAIL reset_cnt got %0d want 0", a_cnt); end
        n_cmp++; if (a_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", a_ready_o); end
        n_cmp++; if (b_ready_o !== 1'b1 || b_cnt !== 4'd0) begin n_err++; $display("FAIL reset_b got ready=%b cnt=%0d want 1/0", b_ready_o, b_cnt); end
        #10;
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        a_ready_i = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            a_valid = 1'b1;
            a_data  = AD_W'(k);
            a_ctrl  = 9'(k);
            exp_q.push_back(AD_W'(k));
            tick();
            exp_v = exp_q.pop_front();
            n_cmp++;
            if (a_valid_o !== 1'b1 || a_data_o !== exp_v || a_ready_o !== 1'b1) begin
                n_err++;
                $display("FAIL stream_%0d got v=%b d=%0h r=%b want v=1 d=%0h r=1", k, a_valid_o, a_data_o, a_ready_o, exp_v);
            end
        end
        a_valid = 1'b0;
        tick();
        n_cmp++; if (a_valid_o !== 1'b0) begin n_err++; $display("FAIL stream_drain got %b want 0", a_valid_o); end
    endtask

    task automatic test_backpressure();
        a_clr = 1'b1;
        tick();
        a_clr = 1'b0;
        n_cmp++; if (a_cnt !== 16'd0) begin n_err++; $display("FAIL bp_clr got %0d want 0", a_cnt); end
        a_ready_i = 1'b0;
        a_valid = 1'b1; a_data = AD_W'(8'h11); exp_q.push_back(AD_W'(8'h11));
        tick();
        a_data = AD_W'(8'h22); exp_q.push_back(AD_W'(8'h22));
        tick();
        a_valid = 1'b0;
        tick();
        tick();
        n_cmp++; if (a_state !== ST_FULL) begin n_err++; $display("FAIL bp_state got %b want %b", a_state, ST_FULL); end
        n_cmp++; if (a_ready_o !== 1'b0) begin n_err++; $display("FAIL bp_ready got %b want 0", a_ready_o); end
        n_cmp++; if (a_data_o !== exp_q[0]) begin n_err++; $display("FAIL bp_head got %0h want %0h", a_data_o, exp_q[0]); end
        n_cmp++; if (a_cnt !== 16'd3) begin n_err++; $display("FAIL bp_cnt got %0d want 3", a_cnt); end
        a_ready_i = 1'b1;
        for (int j = 0; j < 2; j++) begin
            exp_v = exp_q.pop_front();
            n_cmp++;
            if (a_valid_o !== 1'b1 || a_data_o !== exp_v) begin
                n_err++;
                $display("FAIL bp_out_%0d got v=%b d=%0h want v=1 d=%0h", j, a_valid_o, a_data_o, exp_v);
            end
            tick();
        end
        n_cmp++; if (a_valid_o !== 1'b0) begin n_err++; $display("FAIL bp_empty got %b want 0", a_valid_o); end
        n_cmp++; if (a_cnt !== 16'd3) begin n_err++; $display("FAIL bp_cnt_hold got %0d want 3", a_cnt); end
    endtask

    task automatic test_flush();
        a_ready_i = 1'b0;
        a_valid = 1'b1; a_data = AD_W'(8'h44); a_ctrl = 9'h0A5;
        tick();
        a_data = AD_W'(8'h55); a_ctrl = 9'h05A;
        tick();
        n_cmp++; if (a_state !== ST_FULL) begin n_err++; $display("FAIL fl_pre got %b want %b", a_state, ST_FULL); end
        a_flush = 1'b1; a_data = AD_W'(8'h33); a_ctrl = 9'h1FF;
        tick();
        n_cmp++; if (a_valid_o !== 1'b0 || a_ctrl_o !== 9'h0) begin n_err++; $display("FAIL fl_kill got v=%b c=%h want 0/0", a_valid_o, a_ctrl_o); end
        n_cmp++; if (a_ready_o !== 1'b1) begin n_err++; $display("FAIL fl_ready got %b want 1", a_ready_o); end
        n_cmp++; if (a_data_o !== AD_W'(8'h44)) begin n_err++; $display("FAIL fl_data_hold got %0h want 44", a_data_o); end
        // flush while the empty stage accepts: the entry must be dropped
        tick();
        n_cmp++; if (a_valid_o !== 1'b0 || a_data_o !== AD_W'(8'h44)) begin n_err++; $display("FAIL fl_drop got v=%b d=%0h want 0/44", a_valid_o, a_data_o); end
        a_flush = 1'b0; a_valid = 1'b0; a_ready_i = 1'b1;
        for (int j = 0; j < 3; j++) begin
            tick();
            n_cmp++; if (a_valid_o !== 1'b0 || a_data_o === AD_W'(8'h33)) begin n_err++; $display("FAIL fl_after_%0d got v=%b d=%0h want v=0 d!=33", j, a_valid_o, a_data_o); end
        end
    endtask

    task automatic test_ctrl_clear();
        a_ready_i = 1'b1;
        a_valid = 1'b1; a_data = AD_W'(8'h77); a_ctrl = pack_ctrl(1'b1, 2'b10, 2'b01, 1'b0, 3'b101);
        tick();
        n_cmp++; if (a_ctrl_o !== 9'h14D) begin n_err++; $display("FAIL cc_live got %h want 14d", a_ctrl_o); end
        a_valid = 1'b0; a_ctrl = 9'h1FF;
        tick();
        n_cmp++; if (a_valid_o !== 1'b0 || a_ctrl_o !== 9'h0 || a_data_o !== AD_W'(8'h77)) begin
            n_err++; $display("FAIL cc_bubble got v=%b c=%h d=%0h want 0/0/77", a_valid_o, a_ctrl_o, a_data_o);
        end
        b_ready_i = 1'b1;
        b_valid = 1'b1; b_data = 8'h5A; b_ctrl = 9'h0C3;
        tick();
        n_cmp++; if (b_valid_o !== 1'b1 || b_data_o !== 8'h5A || b_ctrl_o !== 9'h0C3) begin
            n_err++; $display("FAIL cc_b_live got v=%b d=%h c=%h want 1/5a/0c3", b_valid_o, b_data_o, b_ctrl_o);
        end
        b_valid = 1'b0; b_ctrl = 9'h1FF;
        tick();
        n_cmp++; if (b_valid_o !== 1'b0 || b_ctrl_o !== 9'h0C3) begin n_err++; $display("FAIL cc_b_hold got v=%b c=%h want 0/0c3", b_valid_o, b_ctrl_o); end
    endtask

    task automatic test_sat_counter();
        logic [3:0] exp_c;
        b_clr = 1'b1;
        tick();
        b_clr = 1'b0;
        b_ready_i = 1'b0; b_valid = 1'b1; b_data = 8'h9C;
        tick();
        b_valid = 1'b0;
        n_cmp++; if (b_cnt !== 4'd0 || b_ready_o !== 1'b0) begin n_err++; $display("FAIL sc_start got cnt=%0d r=%b want 0/0", b_cnt, b_ready_o); end
        for (int k = 1; k <= 20; k++) begin
            tick();
            exp_c = (k > 15) ? 4'd15 : 4'(k);
            n_cmp++; if (b_cnt !== exp_c) begin n_err++; $display("FAIL sc_stall_%0d got %0d want %0d", k, b_cnt, exp_c); end
        end
        b_ready_i = 1'b1;
        #1;
        n_cmp++; if (b_ready_o !== 1'b1) begin n_err++; $display("FAIL sc_comb_ready got %b want 1", b_ready_o); end
        b_ready_i = 1'b0;
        #1;
        n_cmp++; if (b_ready_o !== 1'b0) begin n_err++; $display("FAIL sc_comb_stall got %b want 0", b_ready_o); end
        b_clr = 1'b1;
        tick();
        b_clr = 1'b0;
        n_cmp++; if (b_cnt !== 4'd0) begin n_err++; $display("FAIL sc_clr got %0d want 0", b_cnt); end
        tick();
        n_cmp++; if (b_cnt !== 4'd1) begin n_err++; $display("FAIL sc_after1 got %0d want 1", b_cnt); end
        tick();
        n_cmp++; if (b_cnt !== 4'd2) begin n_err++; $display("FAIL sc_after2 got %0d want 2", b_cnt); end
        b_flush = 1'b1;
        tick();
        b_flush = 1'b0;
        n_cmp++; if (b_cnt !== 4'd3 || b_valid_o !== 1'b0) begin n_err++; $display("FAIL sc_flush got cnt=%0d v=%b want 3/0", b_cnt, b_valid_o); end
        tick();
        n_cmp++; if (b_cnt !== 4'd3) begin n_err++; $display("FAIL sc_flush_hold got %0d want 3", b_cnt); end
        b_ready_i = 1'b1;
    endtask

    task automatic test_reset_mid_stream();
        logic [AD_W-1:0] aa;
        for (int i = 0; i < AD_W; i++) aa[i] = (i % 2 == 1);
        a_ready_i = 1'b0;
        a_valid = 1'b1; a_data = aa; a_ctrl = 9'h1AB;
        tick();
        a_data = AD_W'(8'h66);
        tick();
        a_valid = 1'b0;
        tick();
        n_cmp++; if (a_state !== ST_FULL || a_data_o !== aa) begin n_err++; $display("FAIL rm_pre got st=%b d=%0h want %b/aa..", a_state, a_data_o, ST_FULL); end
        rstn = 1'b0;
        #1;
        n_cmp++; if (a_valid_o !== 1'b0 || a_ctrl_o !== 9'h0) begin n_err++; $display("FAIL rm_vc got v=%b c=%h want 0/0", a_valid_o, a_ctrl_o); end
        n_cmp++; if (a_data_o !== '0 || a_cnt !== 16'd0) begin n_err++; $display("FAIL rm_dc got d=%0h cnt=%0d want 0/0", a_data_o, a_cnt); end
        #2;
        rstn = 1'b1;
        #1;
        n_cmp++; if (a_ready_o !== 1'b1 || a_state !== ST_EMPTY) begin n_err++; $display("FAIL rm_release got r=%b st=%b want 1/00", a_ready_o, a_state); end
        tick();
        n_cmp++; if (a_valid_o !== 1'b0) begin n_err++; $display("FAIL rm_lost got %b want 0", a_valid_o); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_ctrl_clear();
        test_sat_counter();
        test_reset_mid_stream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
